// File: rtl/audio_adc_receiver.sv
// audio_adc_receiver
// Captures I2S stereo ADC data (BCLK / ADC_LR_CLK / ADC_DATA, asynchronous to clk)
// into left/right word pairs and presents them on a valid/ready interface.
// The three serial inputs are synchronized into clk. Edges are then detected on
// the synchronized copies, so clk must run at least 8x BCLK.
// Build option: define ADC_FIFO_EN to buffer FIFO_DEPTH stereo pairs; without it
// a single holding register is used and FIFO_DEPTH has no effect.
module audio_adc_receiver #(
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                BCLK,
  input  logic                ADC_LR_CLK,
  input  logic                ADC_DATA,
  output logic [SAMPLE_W-1:0] left_sample,
  output logic [SAMPLE_W-1:0] right_sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                clr_overrun
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } state_t;

  logic [1:0]          bclk_sync_r;
  logic [1:0]          lr_sync_r;
  logic [1:0]          data_sync_r;
  logic                bclk_prev_r;
  logic                lr_prev_r;
  logic [1:0]          warm_cnt_r;
  logic                edges_ok_s;
  logic                bclk_rise_s;
  logic                lr_edge_s;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                start_slot_s;
  logic                shift_en_s;
  logic                slot_done_s;
  logic [SAMPLE_W-1:0] shift_r;
  logic [SAMPLE_W-1:0] full_word_s;
  logic [SAMPLE_W-1:0] trunc_word_s;
  logic [SAMPLE_W-1:0] done_word_s;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic                slot_right_r;

  logic [SAMPLE_W-1:0] left_latch_r;
  logic                left_have_r;
  logic                commit_r;
  logic [SAMPLE_W-1:0] commit_left_r;
  logic [SAMPLE_W-1:0] commit_right_r;

  logic                valid_r;
  logic                push_s;
  logic                pop_s;
  logic                overrun_r;

  // Two-flop synchronizers, edge-detect history and post-reset warm-up counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_r <= 2'b00;
      lr_sync_r   <= 2'b00;
      data_sync_r <= 2'b00;
      bclk_prev_r <= 1'b0;
      lr_prev_r   <= 1'b0;
      warm_cnt_r  <= 2'd0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[0], BCLK};
      lr_sync_r   <= {lr_sync_r[0], ADC_LR_CLK};
      data_sync_r <= {data_sync_r[0], ADC_DATA};
      bclk_prev_r <= bclk_sync_r[1];
      lr_prev_r   <= lr_sync_r[1];
      if (warm_cnt_r != 2'd3) begin
        warm_cnt_r <= warm_cnt_r + 2'd1;
      end
    end
  end

  // The synchronizers come out of reset at zero, so a line already high would
  // look like an edge; edges are ignored until the pipeline holds real samples.
  assign edges_ok_s   = (warm_cnt_r == 2'd3);
  assign bclk_rise_s  = edges_ok_s & bclk_sync_r[1] & ~bclk_prev_r;
  assign lr_edge_s    = edges_ok_s & (lr_sync_r[1] ^ lr_prev_r);

  // Word on the last bit of a full slot, and a short slot left-justified with zero LSBs.
  assign full_word_s  = {shift_r[SAMPLE_W-2:0], data_sync_r[1]};
  assign trunc_word_s = shift_r << (CNT_W'(SAMPLE_W) - bit_cnt_r);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ALIGN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and slot control strobes.
  always_comb begin
    state_nxt_s  = state_r;
    start_slot_s = 1'b0;
    shift_en_s   = 1'b0;
    slot_done_s  = 1'b0;
    done_word_s  = full_word_s;
    case (state_r)
      ALIGN: begin
        if (lr_edge_s) begin
          start_slot_s = 1'b1;
          state_nxt_s  = DELAY;
        end else begin
          state_nxt_s  = ALIGN;
        end
      end
      DELAY: begin
        if (lr_edge_s) begin
          start_slot_s = 1'b1;
          state_nxt_s  = DELAY;
        end else if (bclk_rise_s) begin
          state_nxt_s  = SHIFT;
        end else begin
          state_nxt_s  = DELAY;
        end
      end
      SHIFT: begin
        if (lr_edge_s) begin
          slot_done_s  = 1'b1;
          done_word_s  = trunc_word_s;
          start_slot_s = 1'b1;
          state_nxt_s  = DELAY;
        end else if (bclk_rise_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == CNT_W'(SAMPLE_W - 1)) begin
            slot_done_s = 1'b1;
            state_nxt_s = PAD;
          end else begin
            state_nxt_s = SHIFT;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      PAD: begin
        if (lr_edge_s) begin
          start_slot_s = 1'b1;
          state_nxt_s  = DELAY;
        end else begin
          state_nxt_s  = PAD;
        end
      end
      default: begin
        state_nxt_s = ALIGN;
      end
    endcase
  end

  // Channel shift register, bit counter and slot channel tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r      <= {SAMPLE_W{1'b0}};
      bit_cnt_r    <= {CNT_W{1'b0}};
      slot_right_r <= 1'b0;
    end else if (start_slot_s) begin
      shift_r      <= {SAMPLE_W{1'b0}};
      bit_cnt_r    <= {CNT_W{1'b0}};
      slot_right_r <= lr_sync_r[1];
    end else if (shift_en_s) begin
      shift_r      <= full_word_s;
      bit_cnt_r    <= bit_cnt_r + CNT_W'(1);
    end
  end

  // Left-word latch and pair commit; a right word without a prior left is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_latch_r   <= {SAMPLE_W{1'b0}};
      left_have_r    <= 1'b0;
      commit_r       <= 1'b0;
      commit_left_r  <= {SAMPLE_W{1'b0}};
      commit_right_r <= {SAMPLE_W{1'b0}};
    end else begin
      commit_r <= 1'b0;
      if (slot_done_s && !slot_right_r) begin
        left_latch_r <= done_word_s;
        left_have_r  <= 1'b1;
      end else if (slot_done_s && left_have_r) begin
        commit_r       <= 1'b1;
        commit_left_r  <= left_latch_r;
        commit_right_r <= done_word_s;
        left_have_r    <= 1'b0;
      end
    end
  end

  assign pop_s = valid_r & sample_ready;

`ifdef ADC_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  logic [SAMPLE_W-1:0] mem_left_r  [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_right_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [FCNT_W-1:0]   fifo_cnt_r;
  logic [FCNT_W-1:0]   fifo_cnt_nxt_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // A full FIFO still accepts a pair when the head leaves on the same edge.
  assign push_s = commit_r & ((fifo_cnt_r != FCNT_W'(FIFO_DEPTH)) | pop_s);

  // Occupancy after this edge's push/pop.
  always_comb begin
    fifo_cnt_nxt_s = fifo_cnt_r;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + FCNT_W'(1);
      2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - FCNT_W'(1);
      default: fifo_cnt_nxt_s = fifo_cnt_r;
    endcase
  end

  // Stereo FIFO storage, pointers, occupancy and registered valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_left_r[i]  <= {SAMPLE_W{1'b0}};
        mem_right_r[i] <= {SAMPLE_W{1'b0}};
      end
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {FCNT_W{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_left_r[wr_ptr_r]  <= commit_left_r;
        mem_right_r[wr_ptr_r] <= commit_right_r;
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      fifo_cnt_r <= fifo_cnt_nxt_s;
      valid_r    <= (fifo_cnt_nxt_s != {FCNT_W{1'b0}});
    end
  end

  assign left_sample  = mem_left_r[rd_ptr_r];
  assign right_sample = mem_right_r[rd_ptr_r];
`else
  logic [SAMPLE_W-1:0] hold_left_r;
  logic [SAMPLE_W-1:0] hold_right_r;

  // An occupied holding register still accepts a pair when it is read on the same edge.
  assign push_s = commit_r & (~valid_r | pop_s);

  // Single stereo holding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_left_r  <= {SAMPLE_W{1'b0}};
      hold_right_r <= {SAMPLE_W{1'b0}};
      valid_r      <= 1'b0;
    end else if (push_s) begin
      hold_left_r  <= commit_left_r;
      hold_right_r <= commit_right_r;
      valid_r      <= 1'b1;
    end else if (pop_s) begin
      valid_r      <= 1'b0;
    end
  end

  assign left_sample  = hold_left_r;
  assign right_sample = hold_right_r;
`endif

  // Sticky overrun; a drop on the same edge as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_r <= 1'b0;
    end else if (commit_r && !push_s) begin
      overrun_r <= 1'b1;
    end else if (clr_overrun) begin
      overrun_r <= 1'b0;
    end
  end

  assign sample_valid = valid_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_audio_adc_receiver.sv
// tb_audio_adc_receiver
// I2S BFM (BCLK = clk/16) driving audio_adc_receiver. Expected pairs are pushed
// into a scoreboard queue when a pair is sent; a monitor pops and compares on
// every valid&&ready transfer. Expected words come from the bits actually put
// on the wire: the first SAMPLE_W bits after the delay bit, MSB first, zero-filled.
module tb_audio_adc_receiver;

  localparam int SW = 24;
`ifdef ADC_FIFO_EN
  localparam int STORE_DEPTH = 4;
`else
  localparam int STORE_DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          BCLK = 1'b0;
  logic          ADC_LR_CLK = 1'b1;
  logic          ADC_DATA = 1'b0;
  logic [SW-1:0] left_sample;
  logic [SW-1:0] right_sample;
  logic          sample_valid;
  logic          sample_ready = 1'b1;
  logic          overrun;
  logic          clr_overrun = 1'b0;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc = 0;
  int            last_rise_cyc = 0;
  int            valid_rise_cyc = -1;
  int            ready_mode = 1;
  logic [47:0]   exp_q[$];
  logic [47:0]   mon_e;
  logic          valid_prev = 1'b0;
  logic          hold_prev = 1'b0;
  logic [47:0]   hold_data = 48'h0;

  audio_adc_receiver #(.SAMPLE_W(SW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .BCLK         (BCLK),
    .ADC_LR_CLK   (ADC_LR_CLK),
    .ADC_DATA     (ADC_DATA),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: first SW bits after the delay bit, MSB first, zero-filled when short.
  function automatic logic [SW-1:0] slot_word(input logic [63:0] hb, input int len);
    logic [SW-1:0] w = '0;
    for (int i = 1; i < len && i <= SW; i++) w[SW - i] = hb[i];
    return w;
  endfunction

  function automatic logic [63:0] make_half(input logic [31:0] val, input int nbits);
    logic [63:0] hb = {$urandom, $urandom};
    for (int i = 1; i <= nbits; i++) hb[i] = val[nbits - i];
    return hb;
  endfunction

  // sample_ready driver: 0 = hold low, 1 = hold high, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       sample_ready = 1'b0;
      1:       sample_ready = 1'b1;
      default: sample_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid && !valid_prev) valid_rise_cyc = cyc;
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pair: got %0h/%0h expected none", left_sample, right_sample);
        end else begin
          mon_e = exp_q.pop_front();
          check("left_sample", 64'(left_sample), 64'(mon_e[47:24]));
          check("right_sample", 64'(right_sample), 64'(mon_e[23:0]));
        end
      end
      if (sample_valid && !sample_ready && hold_prev)
        check("hold_stable", 64'({left_sample, right_sample}), 64'(hold_data));
      hold_prev  = sample_valid && !sample_ready;
      hold_data  = {left_sample, right_sample};
      valid_prev = sample_valid;
    end else begin
      valid_prev = 1'b0;
      hold_prev  = 1'b0;
    end
  end

  // One BCLK period: data/LR change with BCLK low, BCLK high for the second half.
  task automatic send_bit(input logic lr, input logic d, input bit mark, input bit do_rst);
    BCLK = 1'b0;
    ADC_LR_CLK = lr;
    ADC_DATA = d;
    repeat (8) @(negedge clk);
    BCLK = 1'b1;
    if (mark) last_rise_cyc = cyc;
    if (do_rst) begin
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_left", 64'(left_sample), 64'h0);
      check("midrst_right", 64'(right_sample), 64'h0);
      check("midrst_valid", 64'(sample_valid), 64'h0);
      check("midrst_overrun", 64'(overrun), 64'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_half(input logic lr, input logic [63:0] hb, input int len, input int rst_idx);
    for (int i = 0; i < len; i++) send_bit(lr, hb[i], lr && (i == SW), i == rst_idx);
  endtask

  task automatic send_pair(input logic [63:0] lh, input int ll, input logic [63:0] rh, input int rl,
                           input bit push_model);
    if (push_model) exp_q.push_back({slot_word(lh, ll), slot_word(rh, rl)});
    send_half(1'b0, lh, ll, -1);
    send_half(1'b1, rh, rl, -1);
  endtask

  // Closes a truncated right slot with an LR edge, then idles with LR high and BCLK stopped.
  task automatic flush();
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    BCLK = 1'b0;
    ADC_LR_CLK = 1'b1;
    ADC_DATA = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || sample_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < 3000), 64'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  function automatic int rand_len();
    case ($urandom_range(0, 4))
      0:       return 17;
      1:       return 21;
      2:       return 25;
      3:       return 32;
      default: return 33;
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] lh;
    logic [63:0] rh;
    int          ll;
    int          rl;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_left", 64'(left_sample), 64'h0);
    check("rst_right", 64'(right_sample), 64'h0);
    check("rst_valid", 64'(sample_valid), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Full 24-bit slots in 32-bit halves, with output latency.
    ready_mode = 1;
    exp_q.push_back({24'hABCDEF, 24'h123456});
    valid_rise_cyc = -1;
    send_pair(make_half(32'hABCDEF, 24), 32, make_half(32'h123456, 24), 32, 1'b0);
    check("latency", 64'(valid_rise_cyc - last_rise_cyc), 64'd4);
    flush();
    wait_drain();

    // Short 16-bit slots are zero-filled.
    exp_q.push_back({24'hBEEF00, 24'hCAFE00});
    send_pair(make_half(32'hBEEF, 16), 17, make_half(32'hCAFE, 16), 17, 1'b0);
    flush();
    wait_drain();

    // Six pairs with the consumer stalled.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 6; p++) begin
      lh = {$urandom, $urandom};
      rh = {$urandom, $urandom};
      send_pair(lh, 32, rh, 32, p < STORE_DEPTH);
    end
    flush();
    repeat (20) @(negedge clk);
    check("ovr_set", 64'(overrun), 64'h1);
    check("ovr_valid", 64'(sample_valid), 64'h1);
    ready_mode = 1;
    wait_drain();
    check("ovr_sticky", 64'(overrun), 64'h1);
    @(posedge clk);
    #1 clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 64'(overrun), 64'h0);

    // Stream starting mid right slot after reset.
    do_reset();
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) send_pair({$urandom, $urandom}, 32, {$urandom, $urandom}, 32, 1'b1);
    flush();
    wait_drain();

    // Stream starting mid left slot: the first right slot has no left word.
    ADC_LR_CLK = 1'b0;
    repeat (8) @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    send_half(1'b1, {$urandom, $urandom}, 32, -1);
    send_pair({$urandom, $urandom}, 32, {$urandom, $urandom}, 32, 1'b1);
    flush();
    wait_drain();

    // Reset during the 10th bit of a right slot.
    send_half(1'b0, {$urandom, $urandom}, 32, -1);
    send_half(1'b1, {$urandom, $urandom}, 32, 10);
    send_pair({$urandom, $urandom}, 32, {$urandom, $urandom}, 32, 1'b1);
    flush();
    wait_drain();
    check("ovr_after_rst", 64'(overrun), 64'h0);

    // Random data, random slot lengths, random consumer readiness.
    ready_mode = 2;
    for (int p = 0; p < 16; p++) begin
      lh = {$urandom, $urandom};
      rh = {$urandom, $urandom};
      ll = rand_len();
      rl = rand_len();
      send_pair(lh, ll, rh, rl, 1'b1);
    end
    flush();
    ready_mode = 1;
    wait_drain();
    check("rand_no_overrun", 64'(overrun), 64'h0);
    check("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_adc_receiver.md
AUDIO_ADC_RECEIVER -- requirements
Module: audio_adc_receiver

Interface
REQ-001 Parameter: SAMPLE_W, 24, bits per channel sample, the same width as the mixer/DAC path.
REQ-002 Parameter: FIFO_DEPTH, 4, stereo-pair entries; used only when ADC_FIFO_EN is defined.
REQ-003 Port: clk, input, 1, system clock (CLOCK_50 domain); it is the one clock.
REQ-004 Port: reset_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port: BCLK, input, 1, codec bit clock, treated as asynchronous to clk.
REQ-006 Port: ADC_LR_CLK, input, 1, ADC frame clock: low = left slot, high = right slot.
REQ-007 Port: ADC_DATA, input, 1, serial ADC data, I2S format, MSB first.
REQ-008 Port: left_sample, output, SAMPLE_W, left sample of the head stereo pair.
REQ-009 Port: right_sample, output, SAMPLE_W, right sample of the head stereo pair.
REQ-010 Port: sample_valid, output, 1, head pair available.
REQ-011 Port: sample_ready, input, 1, consumer accepts the head pair.
REQ-012 Port: overrun, output, 1, sticky flag: a completed pair was dropped.
REQ-013 Port: clr_overrun, input, 1, synchronous clear of overrun.

Function
REQ-014 BCLK, ADC_LR_CLK and ADC_DATA shall each pass through a 2-flop synchronizer; edges are detected on the synchronized copies; clk shall be >= 8x BCLK.
REQ-015 FSM states: ALIGN, DELAY, SHIFT, PAD.
- ALIGN: after reset; wait for any ADC_LR_CLK edge, then go to DELAY.
- DELAY: skip the first BCLK rise after the LR edge (I2S one-bit delay), then go to SHIFT.
- SHIFT: sample ADC_DATA on each BCLK rise into the MSB-first channel shift register; after SAMPLE_W bits, go to PAD.
- PAD: ignore further bits until the next LR edge, then go to DELAY.
REQ-016 An LR edge in any state other than ALIGN shall restart the slot in DELAY.
REQ-017 Short slot: if the LR edge arrives before SAMPLE_W bits, the unreceived LSBs shall be zero-filled and the channel shall still count as complete.
REQ-018 Bits beyond SAMPLE_W in a slot shall be discarded.
REQ-019 The left word shall be latched at the end of a left slot. A pair shall commit when the right slot completes (SAMPLE_W bits received, or truncated by the LR edge) and a left word has been latched since the last commit.
REQ-020 A right slot with no preceding left word (first slot after ALIGN) shall be discarded.
REQ-021 Latency: sample_valid shall rise exactly 4 clk cycles after the BCLK input rise that carries the last right bit when the output is empty (2 sync + 1 edge + 1 register).
REQ-022 Handshake: a pair transfers on a clk edge with sample_valid && sample_ready. While sample_valid is high and sample_ready is low, left_sample and right_sample shall be stable.
REQ-023 A commit while storage is full shall drop the new pair, keep the stored data, and set overrun.
REQ-024 A commit coinciding with a pop at full storage shall not overrun.
REQ-025 overrun shall hold until clr_overrun is high for one clk. A simultaneous set and clear shall leave overrun set.

Reset
REQ-026 When reset_n is low: FSM = ALIGN; shift register, left latch, bit counter and FIFO pointers = 0; left_sample = 0, right_sample = 0, sample_valid = 0, overrun = 0.
REQ-027 Reset mid-frame shall discard the partial pair and all stored pairs. After release, output resumes only after a fresh LR edge and a full left+right pair.

Configuration
REQ-028 With ADC_FIFO_EN defined, storage shall be a FIFO_DEPTH-entry stereo FIFO; pairs pop in arrival order and outputs show the head entry.
REQ-029 With ADC_FIFO_EN undefined, storage shall be a single holding register (depth 1); FIFO_DEPTH is ignored.

Verification
REQ-030 Bench BFM (BCLK = clk/16, 24-bit slots, 32-bit frame halves, sample_ready = 1) sends left 0xABCDEF, right 0x123456 -> one pulse with left_sample = 0xABCDEF, right_sample = 0x123456, 4 clk after the last right BCLK rise.
REQ-031 Short 16-bit slots, left 0xBEEF, right 0xCAFE -> left_sample = 0xBEEF00, right_sample = 0xCAFE00.
REQ-032 sample_ready = 0, 6 pairs sent -> with ADC_FIFO_EN, pairs 1-4 are retained and read in order, and overrun = 1. Without ADC_FIFO_EN, pair 1 is retained and overrun = 1. clr_overrun then drives overrun to 0.
REQ-033 Stream start mid right slot after reset -> the first right slot is discarded, and the first output pair is the next complete left+right pair.
REQ-034 reset_n pulsed low during the 10th bit of a right slot -> outputs 0 immediately, no valid for the partial pair, correct data from the next full pair.
